// File: rtl/ysyx_24100027_muldiv_seq.sv
// Sequential RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency: result valid 33 cycles after the request handshake; divide-by-zero/overflow are valid the cycle after.
// Backpressure: accepts only when idle; the result is held in DONE until out_ready, and flush aborts at any point.
module ysyx_24100027_muldiv_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q;
   logic [2:0]  op_q;
   logic        neg1_q, neg2_q;
   logic [31:0] opa_q;      // multiplicand or divisor magnitude
   logic [63:0] acc_q;      // {hi, lo} product, or {remainder, quotient}
   logic [31:0] result_q;

   logic        sgn1, sgn2, neg1, neg2;
   logic [31:0] mag1, mag2;
   logic        div_zero, div_ovf, special;
   logic [31:0] special_res;
   logic        hs;

   logic [32:0] sum, trial, diff;
   logic [63:0] acc_nxt, prod;
   logic [31:0] q_res, r_res, res_calc;

   // Decode the incoming request: signedness, magnitudes and the two results that need no iteration.
   always_comb begin
      sgn1 = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      sgn2 = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      neg1 = sgn1 && src1[31];
      neg2 = sgn2 && src2[31];
      mag1 = neg1 ? -src1 : src1;
      mag2 = neg2 ? -src2 : src2;
      div_zero = op[2] && (src2 == 32'd0);
      div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                 (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF);
      special  = div_zero || div_ovf;
      special_res = 32'd0;
      if (div_zero)
         special_res = op[1] ? src1 : 32'hFFFF_FFFF;
      else if (div_ovf)
         special_res = op[1] ? 32'd0 : 32'h8000_0000;
      hs = in_valid && (state_q == S_IDLE) && !flush;
   end

   // One iteration of the datapath and the sign-corrected result it would produce if it were the last.
   always_comb begin
      sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
      trial = acc_q[63:31];
      diff  = trial - {1'b0, opa_q};
      if (op_q[2])
         acc_nxt = diff[32] ? {trial[31:0], acc_q[30:0], 1'b0}
                            : {diff[31:0],  acc_q[30:0], 1'b1};
      else
         acc_nxt = {sum, acc_q[31:1]};
      prod  = (neg1_q ^ neg2_q) ? -acc_nxt : acc_nxt;
      q_res = (neg1_q ^ neg2_q) ? -acc_nxt[31:0] : acc_nxt[31:0];
      r_res = neg1_q ? -acc_nxt[63:32] : acc_nxt[63:32];
      case (op_q)
         OP_MUL:                        res_calc = prod[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  res_calc = prod[63:32];
         OP_DIV, OP_DIVU:               res_calc = q_res;
         OP_REM, OP_REMU:               res_calc = r_res;
         default:                       res_calc = 32'd0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next state and handshake outputs; flush wins over completion and the result handshake.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (hs)
               state_d = special ? S_DONE : S_CALC;
         end
         S_CALC: begin
            busy = 1'b1;
            if (flush)
               state_d = S_IDLE;
            else if (cnt_q == 6'd31)
               state_d = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (flush || out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Operand latch, iteration and result capture; counter restarts on each accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 6'd0;
         op_q     <= 3'd0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         opa_q    <= 32'd0;
         acc_q    <= 64'd0;
         result_q <= 32'd0;
      end else if (hs) begin
         op_q   <= op;
         neg1_q <= neg1;
         neg2_q <= neg2;
         opa_q  <= op[2] ? mag2 : mag1;
         acc_q  <= {32'd0, op[2] ? mag1 : mag2};
         cnt_q  <= 6'd0;
         if (special)
            result_q <= special_res;
      end else if (state_q == S_CALC && !flush) begin
         acc_q <= acc_nxt;
         cnt_q <= cnt_q + 6'd1;
         if (cnt_q == 6'd31)
            result_q <= res_calc;
      end
   end

   assign result = result_q;

endmodule
